haar_stage_sequencer: RTL

//  Owns the stage-parameter memory read port and streams one Haar cascade window evaluation. Walks stage
//  0..NUM_STAGES-1, fetches every classifier parameter word, then the stage-threshold words, tagged with indices.

---
 rtl/haar_stage_sequencer_pkg.sv | 30 +++
 rtl/haar_stage_sequencer_if.sv | 29 ++
 rtl/haar_stage_sequencer_word_skid.sv | 61 ++++++
 rtl/haar_stage_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/haar_stage_sequencer_pkg.sv
// Shared definitions for the Haar stage sequencer: FSM encodings, word kinds,
// the per-word tag carried alongside stream data, and the stage-size helper.
package haar_stage_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic WORD_KIND_PARAM  = 1'b0;
    localparam logic WORD_KIND_THRESH = 1'b1;

    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [7:0]       idx_t;

    typedef struct packed {
        logic is_thresh;
        idx_t stage;
        idx_t classifier;
        idx_t param;
        logic last_param;
        logic last_word;
    } word_tag_t;

    function automatic int size_stage(input int n_cls, input int n_param, input int n_thresh);
        return n_cls * n_param + n_thresh;
    endfunction

endpackage

// File: rtl/haar_stage_sequencer_if.sv
// Word stream from the sequencer to the classifier evaluator, plus the
// evaluator's per-stage verdict travelling back.
interface haar_stage_sequencer_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  word_valid;
    logic                  word_ready;
    logic [DATA_WIDTH-1:0] word_data;
    logic                  word_is_thresh;
    logic [7:0]            index_stage;
    logic [7:0]            index_classifier;
    logic [7:0]            index_param;
    logic                  last_param;
    logic                  last_word;
    logic                  result_valid;
    logic                  result_pass;

    modport master (
        output word_valid, word_data, word_is_thresh, index_stage,
               index_classifier, index_param, last_param, last_word,
        input  word_ready, result_valid, result_pass
    );

    modport slave (
        input  word_valid, word_data, word_is_thresh, index_stage,
               index_classifier, index_param, last_param, last_word,
        output word_ready, result_valid, result_pass
    );
endinterface

// File: rtl/haar_stage_sequencer_word_skid.sv
// Two-entry valid/ready buffer holding returned memory words with their tags;
// the head entry drives the stream and stays put until accepted.
module haar_stage_sequencer_word_skid
    import haar_stage_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  word_tag_t             push_tag,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output word_tag_t             tag,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] data_q [2];
    word_tag_t             tag_q  [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count_q;
    logic                  pop;

    assign valid = (count_q != 2'd0);
    assign pop   = valid & ready;
    assign data  = data_q[rd_ptr];
    assign tag   = tag_q[rd_ptr];
    assign count = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the storage is reset as well so the stream outputs read zero straight out of reset.
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                tag_q[wr_ptr]  <= push_tag;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/haar_stage_sequencer.sv
// Walks the cascade stage by stage: reads every stage word from the parameter
// ROM, streams it tagged to the evaluator, then waits for that stage's verdict.
module haar_stage_sequencer
    import haar_stage_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH               = 10,
    parameter int DATA_WIDTH               = 12,
    parameter int NUM_STAGES               = 4,
    parameter int NUM_CLASSIFIERS_STAGE    = 10,
    parameter int NUM_PARAM_PER_CLASSIFIER = 19,
    parameter int NUM_STAGE_THRESHOLD      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    haar_stage_sequencer_if.master stream,
    output logic                  busy,
    output logic                  done,
    output logic                  face
);

    localparam int SIZE_STAGE = size_stage(NUM_CLASSIFIERS_STAGE, NUM_PARAM_PER_CLASSIFIER,
                                           NUM_STAGE_THRESHOLD);
    localparam int CLS_WORDS  = NUM_CLASSIFIERS_STAGE * NUM_PARAM_PER_CLASSIFIER;

    localparam cnt_t                  SIZE_C       = cnt_t'(SIZE_STAGE);
    localparam cnt_t                  LAST_WORD_C  = cnt_t'(SIZE_STAGE - 1);
    localparam cnt_t                  CLS_WORDS_C  = cnt_t'(CLS_WORDS);
    localparam idx_t                  LAST_PARAM_C = idx_t'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam idx_t                  LAST_STAGE_C = idx_t'(NUM_STAGES - 1);
    localparam logic [ADDR_WIDTH-1:0] STAGE_STRIDE = ADDR_WIDTH'(SIZE_STAGE);

    logic [1:0]            state;
    idx_t                  stage;
    logic [ADDR_WIDTH-1:0] stage_base;
    cnt_t                  issue_idx;
    cnt_t                  xfer_cnt;
    idx_t                  cls_cnt;
    idx_t                  param_cnt;
    logic                  inflight;
    word_tag_t             inflight_tag;
    logic                  face_q;

    word_tag_t             issue_tag;
    logic                  stage_clear;
    logic                  pop;
    logic                  skid_valid;
    logic [1:0]            skid_count;
    logic [DATA_WIDTH-1:0] skid_data;
    word_tag_t             skid_tag;

    assign pop = skid_valid & stream.word_ready;

    // Room check credits the word leaving this cycle, so a held-high ready sustains one read per cycle.
    assign mem_ren = (state == ST_FETCH) && !abort && (issue_idx < SIZE_C) &&
                     (({1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);
    assign mem_addr = mem_ren ? (stage_base + ADDR_WIDTH'(issue_idx)) : '0;

    assign stage_clear = abort ||
                         ((state == ST_IDLE) && start) ||
                         ((state == ST_WAIT) && stream.result_valid && stream.result_pass);

    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch behind.
        issue_tag       = '0;
        issue_tag.stage = stage;
        if (issue_idx >= CLS_WORDS_C) begin
            issue_tag.is_thresh = WORD_KIND_THRESH;
            issue_tag.param     = idx_t'(issue_idx - CLS_WORDS_C);
            issue_tag.last_word = (issue_idx == LAST_WORD_C);
        end else begin
            issue_tag.is_thresh  = WORD_KIND_PARAM;
            issue_tag.classifier = cls_cnt;
            issue_tag.param      = param_cnt;
            issue_tag.last_param = (param_cnt == LAST_PARAM_C);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            stage        <= '0;
            stage_base   <= '0;
            issue_idx    <= '0;
            xfer_cnt     <= '0;
            cls_cnt      <= '0;
            param_cnt    <= '0;
            inflight     <= 1'b0;
            inflight_tag <= '0;
            face_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every update here sees last cycle's values.
            inflight <= mem_ren;
            if (mem_ren) begin
                inflight_tag <= issue_tag;
                issue_idx    <= issue_idx + 1'b1;
                if (issue_tag.is_thresh == WORD_KIND_PARAM) begin
                    if (param_cnt == LAST_PARAM_C) begin
                        param_cnt <= '0;
                        cls_cnt   <= cls_cnt + 1'b1;
                    end else begin
                        param_cnt <= param_cnt + 1'b1;
                    end
                end
            end
            if (pop) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end

            // Stage boundaries (and abort) restart the per-stage counters; later writes win.
            if (stage_clear) begin
                issue_idx <= '0;
                xfer_cnt  <= '0;
                cls_cnt   <= '0;
                param_cnt <= '0;
            end

            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state      <= ST_FETCH;
                            stage      <= '0;
                            stage_base <= '0;
                            face_q     <= 1'b0;
                        end
                    end
                    ST_FETCH: begin
                        if (pop && (xfer_cnt == LAST_WORD_C)) begin
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (stream.result_valid) begin
                            if (stream.result_pass && (stage != LAST_STAGE_C)) begin
                                state      <= ST_FETCH;
                                stage      <= stage + 1'b1;
                                stage_base <= stage_base + STAGE_STRIDE;
                            end else begin
                                state  <= ST_DONE;
                                face_q <= stream.result_pass;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // The in-flight return is dropped on abort by the flush, which outranks the push.
    haar_stage_sequencer_word_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (abort),
        .push     (inflight),
        .push_data(mem_data),
        .push_tag (inflight_tag),
        .ready    (stream.word_ready),
        .valid    (skid_valid),
        .data     (skid_data),
        .tag      (skid_tag),
        .count    (skid_count)
    );

    assign stream.word_valid       = skid_valid;
    assign stream.word_data        = skid_data;
    assign stream.word_is_thresh   = skid_tag.is_thresh;
    assign stream.index_stage      = skid_tag.stage;
    assign stream.index_classifier = skid_tag.classifier;
    assign stream.index_param      = skid_tag.param;
    assign stream.last_param       = skid_tag.last_param;
    assign stream.last_word        = skid_tag.last_word;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign face = (state == ST_DONE) && face_q;

endmodule
